// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encodings, parity constants
// and the parity helper used when a byte is captured.
package uart_pkg;

  localparam int MAX_WIDTH = 14;

  typedef enum logic [2:0] {
    IDLE   = 3'b000,
    START  = 3'b001,
    DATA   = 3'b010,
    PARITY = 3'b011,
    STOP   = 3'b100
  } tx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Zero-extension to MAX_WIDTH leaves the XOR reduction unchanged.
  function automatic logic calc_parity(input logic [MAX_WIDTH-1:0] data, input logic par_typ);
    return (^data) ^ (par_typ == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Parallel request/config side and serial output of the UART transmitter.
interface uart_tx_if #(
  parameter int WIDTH          = 8,
  parameter int PRESCALE_WIDTH = 5
);
  logic [WIDTH-1:0]          P_DATA;
  logic                      Data_Valid;
  logic                      PAR_EN;
  logic                      PAR_TYP;
  logic [PRESCALE_WIDTH-1:0] Prescale;
  logic                      TX_OUT;
  logic                      Busy;

  modport master (
    output P_DATA, Data_Valid, PAR_EN, PAR_TYP, Prescale,
    input  TX_OUT, Busy
  );

  modport slave (
    input  P_DATA, Data_Valid, PAR_EN, PAR_TYP, Prescale,
    output TX_OUT, Busy
  );
endinterface

// File: rtl/uart_tx_serializer.sv
// Shadow data register, bit index and parity for one frame; the FSM in
// uart_tx decides when to load and when to advance to the next bit.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] p_data,
  input  logic             par_typ,
  output logic             bit_nxt,
  output logic             parity,
  output logic             last
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] data_q, data_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             parity_q, parity_d;

  always_comb begin
    data_d   = data_q;
    idx_d    = idx_q;
    parity_d = parity_q;
    if (load) begin
      data_d   = p_data;
      idx_d    = '0;
      parity_d = calc_parity(MAX_WIDTH'(p_data), par_typ);
    end else if (shift) begin
      idx_d = idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      data_q   <= '0;
      idx_q    <= '0;
      parity_q <= 1'b0;
    end else begin
      data_q   <= data_d;
      idx_q    <= idx_d;
      parity_q <= parity_d;
    end
  end

  // Bit that will be on the line once the pending shift takes effect.
  assign bit_nxt = data_q[idx_d];
  assign parity  = parity_q;
  assign last    = (idx_q == IDX_W'(WIDTH - 1));

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: frames a captured word as start, LSB-first data,
// optional parity and stop, holding each bit for Prescale CLK cycles.
//
//   state  | meaning
//   IDLE   | line high, Busy low, waiting for Data_Valid
//   START  | start bit (line low)
//   DATA   | data bit at the serializer's current index
//   PARITY | parity bit of the captured word
//   STOP   | stop bit (line high), then back to IDLE
module uart_tx
  import uart_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int PRESCALE_WIDTH = 5
) (
  input logic     CLK,
  input logic     RST,
  uart_tx_if.slave bus
);

  tx_state_e                 state_q, state_d;
  logic [PRESCALE_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
  logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
  logic                      par_en_q, par_en_d;
  logic                      tx_q, tx_d;
  logic                      busy_q, busy_d;

  logic                      ser_load, ser_shift;
  logic                      ser_bit_nxt, ser_parity, ser_last;
  logic [PRESCALE_WIDTH-1:0] edge_last;
  logic                      bit_end;

  uart_tx_serializer #(.WIDTH(WIDTH)) u_ser (
    .CLK     (CLK),
    .RST     (RST),
    .load    (ser_load),
    .shift   (ser_shift),
    .p_data  (bus.P_DATA),
    .par_typ (bus.PAR_TYP),
    .bit_nxt (ser_bit_nxt),
    .parity  (ser_parity),
    .last    (ser_last)
  );

  // A captured Prescale of 0 behaves like 1: every cycle is a bit end.
  assign edge_last = (prescale_q == '0) ? '0 : prescale_q - PRESCALE_WIDTH'(1);
  assign bit_end   = (edge_cnt_q == edge_last);

  always_comb begin
    state_d    = state_q;
    edge_cnt_d = edge_cnt_q + PRESCALE_WIDTH'(1);
    prescale_d = prescale_q;
    par_en_d   = par_en_q;
    ser_load   = 1'b0;
    ser_shift  = 1'b0;
    if (state_q != IDLE && bit_end) edge_cnt_d = '0;
    case (state_q)
      IDLE: begin
        edge_cnt_d = '0;
        if (bus.Data_Valid) begin
          ser_load   = 1'b1;
          prescale_d = bus.Prescale;
          par_en_d   = bus.PAR_EN;
          state_d    = START;
        end
      end
      START:  if (bit_end) state_d = DATA;
      DATA: begin
        if (bit_end) begin
          if (!ser_last)     ser_shift = 1'b1;
          else if (par_en_q) state_d   = PARITY;
          else               state_d   = STOP;
        end
      end
      PARITY: if (bit_end) state_d = STOP;
      STOP:   if (bit_end) state_d = IDLE;
      default: begin
        state_d    = IDLE;
        edge_cnt_d = '0;
      end
    endcase

    // Outputs follow the next state so they leave the block as flops.
    busy_d = (state_d != IDLE);
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = ser_bit_nxt;
      PARITY:  tx_d = ser_parity;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      edge_cnt_q <= '0;
      prescale_q <= '0;
      par_en_q   <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      edge_cnt_q <= edge_cnt_d;
      prescale_q <= prescale_d;
      par_en_q   <= par_en_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.TX_OUT = tx_q;
  assign bus.Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus queues hand-written frames, a
// monitor checks each bit, frame length, inter-frame gap and idle line.
module tb_uart_tx;

  localparam int W  = 8;
  localparam int PW = 5;

  logic CLK = 1'b0;
  logic RST = 1'b0;

  uart_tx_if #(.WIDTH(W), .PRESCALE_WIDTH(PW)) bus();

  uart_tx #(.WIDTH(W), .PRESCALE_WIDTH(PW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] bits;
    int          nbits;
    int          pw;
    int          gap;
    bit          abort;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   in_frame = 1'b0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // seq lists line levels in transmission order, one char per bit.
  task automatic push_exp(input string seq, input int pw, input int gap, input bit abort);
    exp_t e;
    e.bits  = '0;
    e.nbits = seq.len();
    e.pw    = pw;
    e.gap   = gap;
    e.abort = abort;
    for (int i = 0; i < seq.len(); i++) e.bits[i] = (seq[i] == "1");
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [7:0] d, input logic pe, input logic pt, input logic [4:0] ps);
    bus.P_DATA     = d;
    bus.PAR_EN     = pe;
    bus.PAR_TYP    = pt;
    bus.Prescale   = ps;
    bus.Data_Valid = 1'b1;
    @(posedge CLK); #1;
    bus.Data_Valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(posedge CLK); #1;
      if (exp_q.size() == 0 && !in_frame && !bus.Busy) done = 1'b1;
    end
    if (!done) check({name, "_timeout"}, 0, 1);
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin : monitor
    exp_t cur;
    int   cyc      = 0;
    int   idle_cnt = 0;
    int   k;
    bit   bit_err  = 1'b0;
    bit   skip     = 1'b0;
    logic bit_act  = 1'b0;
    logic bit_req  = 1'b0;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        if (in_frame && !cur.abort) check("unexpected_abort", 1, 0);
        in_frame = 1'b0;
        skip     = 1'b0;
        idle_cnt = 0;
      end else if (skip) begin
        if (!bus.Busy) begin
          skip     = 1'b0;
          idle_cnt = 1;
        end
      end else begin
        if (!in_frame) begin
          if (bus.Busy) begin
            if (exp_q.size() == 0) begin
              check("unexpected_frame", 1, 0);
              skip = 1'b1;
            end else begin
              cur      = exp_q.pop_front();
              in_frame = 1'b1;
              cyc      = 0;
              bit_err  = 1'b0;
              if (cur.gap >= 0) check("gap", idle_cnt, cur.gap);
            end
          end else begin
            idle_cnt++;
            if (bus.TX_OUT !== 1'b1) check("idle_line", int'(bus.TX_OUT), 1);
          end
        end
        if (in_frame) begin
          if (!bus.Busy) begin
            check("busy_len", cyc, cur.nbits * cur.pw);
            check("first_idle_tx", int'(bus.TX_OUT), 1);
            in_frame = 1'b0;
            idle_cnt = 1;
          end else begin
            k = cyc / cur.pw;
            if (k >= cur.nbits) begin
              bit_err = 1'b1;
              bit_act = bus.TX_OUT;
              bit_req = 1'b1;
            end else if (bus.TX_OUT !== cur.bits[k]) begin
              bit_err = 1'b1;
              bit_act = bus.TX_OUT;
              bit_req = cur.bits[k];
            end
            cyc++;
            if (cyc % cur.pw == 0) begin
              n_checks++;
              if (bit_err) begin
                n_fail++;
                $display("FAIL bit%0d: line %b, expected %b", k, bit_act, bit_req);
              end
              bit_err = 1'b0;
            end
            if (cyc > 2000) begin
              check("frame_overrun", cyc, cur.nbits * cur.pw);
              in_frame = 1'b0;
              skip     = 1'b1;
            end
          end
        end
      end
    end
  end

  initial begin : stimulus
    bit seen_idle;
    bus.P_DATA     = '0;
    bus.Data_Valid = 1'b0;
    bus.PAR_EN     = 1'b0;
    bus.PAR_TYP    = 1'b0;
    bus.Prescale   = '0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_tx", int'(bus.TX_OUT), 1);
    check("rst_busy", int'(bus.Busy), 0);
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check("idle_busy", int'(bus.Busy), 0);

    // 0xA5, even parity, 8 cycles/bit
    push_exp("01010010101", 8, -1, 1'b0);
    send(8'hA5, 1'b1, 1'b0, 5'd8);
    check("latency_busy", int'(bus.Busy), 1);
    check("latency_tx", int'(bus.TX_OUT), 0);
    wait_done(200, "a5");

    // 0x01, odd parity, 16 cycles/bit
    push_exp("01000000001", 16, -1, 1'b0);
    send(8'h01, 1'b1, 1'b1, 5'd16);
    wait_done(300, "01");

    // 0xFF, no parity
    push_exp("0111111111", 16, -1, 1'b0);
    send(8'hFF, 1'b0, 1'b0, 5'd16);
    wait_done(300, "ff");

    // 0xC3 frame with mid-frame request/config changes, then back-to-back 0x3C
    push_exp("01100001101", 4, -1, 1'b0);
    send(8'hC3, 1'b1, 1'b0, 5'd4);
    repeat (10) @(posedge CLK);
    #1;
    bus.P_DATA     = 8'h3C;
    bus.PAR_EN     = 1'b0;
    bus.Prescale   = 5'd2;
    bus.Data_Valid = 1'b1;
    @(posedge CLK); #1;
    bus.Data_Valid = 1'b0;
    repeat (10) @(posedge CLK);
    #1;
    push_exp("00011110011", 4, 1, 1'b0);
    bus.PAR_EN     = 1'b1;
    bus.PAR_TYP    = 1'b1;
    bus.Prescale   = 5'd4;
    bus.Data_Valid = 1'b1;
    seen_idle = 1'b0;
    for (int i = 0; i < 100 && !seen_idle; i++) begin
      @(posedge CLK); #1;
      if (!bus.Busy) seen_idle = 1'b1;
    end
    if (!seen_idle) check("b2b_idle_timeout", 0, 1);
    @(posedge CLK); #1;
    bus.Data_Valid = 1'b0;
    check("b2b_accept", int'(bus.Busy), 1);
    wait_done(200, "b2b");

    // Reset during data bit 3 of an 0xA5 frame, then a clean 0x5A frame
    push_exp("01010010101", 8, -1, 1'b1);
    send(8'hA5, 1'b1, 1'b0, 5'd8);
    repeat (35) @(posedge CLK);
    #2;
    RST = 1'b0;
    #1;
    check("abort_tx", int'(bus.TX_OUT), 1);
    check("abort_busy", int'(bus.Busy), 0);
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    check("post_rst_busy", int'(bus.Busy), 0);
    push_exp("00101101001", 8, -1, 1'b0);
    send(8'h5A, 1'b1, 1'b0, 5'd8);
    wait_done(200, "5a");

    // 1-cycle bits with Prescale 0 and 1
    push_exp("0000000011", 1, -1, 1'b0);
    send(8'h80, 1'b0, 1'b0, 5'd0);
    wait_done(50, "ps0");
    push_exp("0000000011", 1, -1, 1'b0);
    send(8'h80, 1'b0, 1'b0, 5'd1);
    wait_done(50, "ps1");

    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter, the companion to the team's UART receive path. It accepts a parallel byte through a valid/busy handshake, frames it as start, data LSB-first, optional parity and stop, and drives the serial line. It runs on the same oversampled clock as the receiver, so each bit is held for Prescale CLK cycles. The block contains the control FSM, serializer, parity generator and bit-timing counters.

Parameters:
WIDTH, 8, data bits per frame (1..14)
PRESCALE_WIDTH, 5, width of Prescale and of the internal edge counter

Ports:
CLK  input  1  system clock (oversampled, Prescale x baud)
RST  input  1  reset, asynchronous, active-low
P_DATA  input  WIDTH  parallel data to send
Data_Valid  input  1  request pulse/level; accepted only when Busy=0
PAR_EN  input  1  1 = insert parity bit
PAR_TYP  input  1  0 = even parity, 1 = odd parity
Prescale  input  PRESCALE_WIDTH  CLK cycles per bit (value 0 treated as 1)
TX_OUT  output  1  serial line, idle high, registered
Busy  output  1  high while a frame is in flight, registered

Behaviour:
- Reset: state IDLE, TX_OUT=1, Busy=0, all counters and shadow registers 0. Reset mid-frame aborts the frame immediately; the line returns high asynchronously.
- Acceptance: in IDLE with Data_Valid=1 at a CLK edge, capture P_DATA, PAR_EN, PAR_TYP and Prescale into shadow registers. Compute parity from captured data: XOR of bits, XOR PAR_TYP.
- Config or data changes after acceptance have no effect on the frame in flight.
- Data_Valid while Busy=1 is ignored. There is no queueing.
- Latency: TX_OUT falls to 0 and Busy rises in the cycle after the accepting edge.
- FSM states:
  - IDLE: TX_OUT=1, Busy=0.
  - START: TX_OUT=0.
  - DATA: TX_OUT=data[bit_cnt], with bit_cnt running 0..WIDTH-1.
  - PARITY: TX_OUT=parity bit.
  - STOP: TX_OUT=1.
- Transitions:
  - IDLE->START on acceptance.
  - START->DATA, DATA->DATA (next bit), DATA->PARITY or STOP, PARITY->STOP and STOP->IDLE each happen on bit-end.
  - After the last data bit, DATA goes to PARITY if captured PAR_EN=1, otherwise to STOP.
- Bit timing: the edge counter counts 0..Prescale_s-1. Bit-end occurs when edge_cnt = Prescale_s-1. The counter resets to 0 on every state change.
- Each serial bit is therefore exactly Prescale_s cycles wide (1 cycle when Prescale_s is 0 or 1).
- Frame duration: (WIDTH+2+PAR_EN) x Prescale_s cycles, which equals the number of cycles Busy is high.
- Back-to-back: Busy falls and TX_OUT stays 1 in the cycle after the last STOP cycle. A Data_Valid sampled in that first IDLE cycle is accepted, so the minimum inter-frame gap is 1 CLK of idle-high line.
- All outputs come straight from flops. TX_OUT never glitches.

Decomposition:
- Shared package uart_pkg holds:
  - Tx state encodings: IDLE=3'b000, START=3'b001, DATA=3'b010, PARITY=3'b011, STOP=3'b100.
  - Parity type constants PAR_EVEN=0, PAR_ODD=1.
- One natural sub-module, uart_tx_serializer. It owns the shadow data register, bit index and parity computation, and the FSM drives its load/shift enables.
- The edge counter and FSM stay in uart_tx.

Test Plan:
- P_DATA=0xA5, PAR_EN=1, PAR_TYP=0, Prescale=8 -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,0,1. Each bit is 8 cycles; parity=0; Busy high for 88 cycles.
- P_DATA=0x01, PAR_EN=1, PAR_TYP=1, Prescale=16 -> parity bit=0; frame is 0,1,0,0,0,0,0,0,0,0,1; Busy high for 176 cycles.
- P_DATA=0xFF, PAR_EN=0, Prescale=16 -> 10 bits (0, eight 1s, 1); Busy high for 160 cycles; no parity slot.
- Second Data_Valid with 0x3C mid-frame, plus P_DATA/PAR_EN changed mid-frame -> both ignored; the first frame is unchanged. Data_Valid in the first idle cycle is then accepted; gap is exactly 1 cycle.
- RST low during DATA bit 3 -> TX_OUT=1 and Busy=0 immediately. After release, a new 0x5A frame transmits correctly.
- Prescale=0 and Prescale=1 with 0x80 -> 1-cycle bits; Busy high for 10 cycles (PAR_EN=0).
